// File: rtl/ofw_pkg.sv
// Shared types and constants for the operand fetch / writeback stage.
// Instruction layout is {op, rd, rs, rt}, most significant field first.
package ofw_pkg;
    localparam int DATA_W   = 4;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 4;
    localparam int INSTR_W  = 9;

    localparam int OP_LSB = 6;
    localparam int OP_W   = 3;
    localparam int RD_LSB = 4;
    localparam int RS_LSB = 2;
    localparam int RT_LSB = 0;

    localparam logic [OP_W-1:0] OP_SUB = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_OR  = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_SRA = 3'd4;
    localparam logic [OP_W-1:0] OP_ROL = 3'd5;
    localparam logic [OP_W-1:0] OP_LT  = 3'd6;
    localparam logic [OP_W-1:0] OP_EQ  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: OP_W];
    endfunction

    function automatic logic [REG_AW-1:0] instr_reg(input logic [INSTR_W-1:0] instr,
                                                   input int lsb);
        return instr[lsb +: REG_AW];
    endfunction
endpackage

// File: rtl/ofw_if.sv
// Bundle of the instruction handshake, register load, ALU and writeback signals.
// The slave modport is the stage itself; master is the surrounding system.
interface ofw_if;
    import ofw_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                ld_en;
    logic [REG_AW-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_data;
    logic [DATA_W-1:0]   alu_rs;
    logic [DATA_W-1:0]   alu_rt;
    logic [OP_W-1:0]     alu_sel;
    logic [DATA_W-1:0]   alu_rd;
    logic                wb_valid;
    logic [REG_AW-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic [REG_AW-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_data;

    modport slave (
        input  in_valid, in_instr, ld_en, ld_addr, ld_data, alu_rd, dbg_addr,
        output in_ready, alu_rs, alu_rt, alu_sel, wb_valid, wb_addr, wb_data, dbg_data
    );

    modport master (
        output in_valid, in_instr, ld_en, ld_addr, ld_data, alu_rd, dbg_addr,
        input  in_ready, alu_rs, alu_rt, alu_sel, wb_valid, wb_addr, wb_data, dbg_data
    );
endinterface

// File: rtl/ofw_regfile.sv
// Small register file: one write port, three combinational read ports.
// Every register clears on the asynchronous reset.
module ofw_regfile #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [AW-1:0]     rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    q_reg <= wdata;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rs_data  = regs[rs_addr];
    assign rt_data  = regs[rt_addr];
    assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/operand_fetch_writeback.sv
// Issue/writeback stage around an external combinational ALU: fetch operands,
// present them to the ALU, capture the result and write it back, one instruction at a time.
module operand_fetch_writeback #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic  clk,
    input  logic  rst,
    ofw_if.slave  bus
);
    import ofw_pkg::*;

    localparam int AW = $clog2(NUM_REGS);

    state_t            state_reg;
    logic [DATA_W-1:0] alu_rs_reg;
    logic [DATA_W-1:0] alu_rt_reg;
    logic [OP_W-1:0]   alu_sel_reg;
    logic [AW-1:0]     dest_reg;
    logic              wb_valid_reg;
    logic [AW-1:0]     wb_addr_reg;
    logic [DATA_W-1:0] wb_data_reg;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              accept;

    // Loads win over instructions, so in_ready drops whenever ld_en is high.
    assign bus.in_ready = (state_reg == IDLE) && !bus.ld_en;
    assign accept       = bus.in_ready && bus.in_valid;

    // Loads happen only in IDLE and writebacks only in WB, so the port is never contended.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = bus.ld_addr;
        rf_wdata = bus.ld_data;
        if (state_reg == WB) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr_reg;
            rf_wdata = wb_data_reg;
        end else if (state_reg == IDLE && bus.ld_en) begin
            rf_we    = 1'b1;
        end
    end

    ofw_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .rs_addr  (instr_reg(bus.in_instr, RS_LSB)),
        .rs_data  (rs_data),
        .rt_addr  (instr_reg(bus.in_instr, RT_LSB)),
        .rt_data  (rt_data),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            alu_rs_reg   <= '0;
            alu_rt_reg   <= '0;
            alu_sel_reg  <= '0;
            dest_reg     <= '0;
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
            wb_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wb_valid_reg <= 1'b0;
                    if (accept) begin
                        alu_rs_reg  <= rs_data;
                        alu_rt_reg  <= rt_data;
                        alu_sel_reg <= instr_op(bus.in_instr);
                        dest_reg    <= instr_reg(bus.in_instr, RD_LSB);
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    wb_valid_reg <= 1'b1;
                    wb_addr_reg  <= dest_reg;
                    wb_data_reg  <= bus.alu_rd;
                    state_reg    <= WB;
                end
                WB: begin
                    wb_valid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    wb_valid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_rs   = alu_rs_reg;
    assign bus.alu_rt   = alu_rt_reg;
    assign bus.alu_sel  = alu_sel_reg;
    assign bus.wb_valid = wb_valid_reg;
    assign bus.wb_addr  = wb_addr_reg;
    assign bus.wb_data  = wb_data_reg;
endmodule
